// File: rtl/pe_action_table_loader_pkg.sv
// Shared types for the PE action table loader: widths, pid type, error and FSM state enums.
// Also holds the helper that classifies a header pid.
package pe_action_table_loader_pkg;

    localparam int PAT_ENTRY_W       = 48;
    localparam int PAT_CFG_W         = 16;
    localparam int PAT_RESERVED_PIDS = 2;
    localparam int PAT_TABLE_SIZE    = 8;

    typedef logic [3:0] pid_t;

    typedef enum logic [1:0] {
        PAT_ERR_NONE   = 2'd0,
        PAT_ERR_RSVD   = 2'd1,
        PAT_ERR_RANGE  = 2'd2,
        PAT_ERR_VERIFY = 2'd3
    } pat_load_err_e;

    typedef enum logic [1:0] {
        PAT_IDLE    = 2'd0,
        PAT_PAYLOAD = 2'd1,
        PAT_WRITE   = 2'd2,
        PAT_VERIFY  = 2'd3
    } pat_load_state_e;

    // Reserved pids are checked before the range, so pid 0/1 always report RSVD.
    function automatic pat_load_err_e pat_pid_class(input pid_t pid, input int table_size);
        int pid_i;
        pid_i = int'({28'd0, pid});
        if (pid_i < PAT_RESERVED_PIDS) return PAT_ERR_RSVD;
        if (pid_i >= table_size)       return PAT_ERR_RANGE;
        return PAT_ERR_NONE;
    endfunction

endpackage

// File: rtl/pe_action_table_loader.sv
// Config-bus loader for the PE action table: header + payload words in, one table write out,
// followed by a combinational readback check that yields load_done or load_err.
module pe_action_table_loader
    import pe_action_table_loader_pkg::*;
#(
    parameter int CFG_W    = PAT_CFG_W,
    parameter int ENTRY_W  = PAT_ENTRY_W,
    parameter int PAT_SIZE = PAT_TABLE_SIZE
) (
    input  logic               clk,
    input  logic               rst_n,
    // Handshake: a word moves on a rising edge where cfg_valid & cfg_ready are both high;
    // cfg_data must be stable while cfg_valid is high and the word has not yet moved.
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CFG_W-1:0]   cfg_data,
    output logic               tbl_write_en,
    output logic [ENTRY_W-1:0] tbl_w_entry,
    output pid_t               tbl_pid,
    input  logic [ENTRY_W-1:0] tbl_entry,
    output logic               busy,
    output logic               load_done,
    output logic               load_err,
    output logic [1:0]         err_code,
    output pat_load_state_e    dbg_state
);

    localparam int NWORDS = (ENTRY_W + CFG_W - 1) / CFG_W;
    localparam int SR_W   = NWORDS * CFG_W;
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

    pat_load_state_e  state_q, state_d;
    pid_t             pid_q;
    pat_load_err_e    class_q;
    pat_load_err_e    code_q;
    pat_load_err_e    fin_code;
    logic [CNT_W-1:0] cnt_q;
    logic [SR_W-1:0]  sr_q;
    logic             ready_int;
    logic             hs;

    assign cfg_ready   = ready_int & rst_n;
    assign hs          = cfg_valid & cfg_ready;
    assign tbl_pid     = pid_q;
    assign tbl_w_entry = sr_q[ENTRY_W-1:0];
    assign busy        = (state_q != PAT_IDLE);
    assign dbg_state   = state_q;
    // The finishing code is visible alongside its pulse, then held from code_q.
    assign err_code    = (load_done | load_err) ? fin_code : code_q;

    always_comb begin
        state_d      = state_q;
        ready_int    = 1'b0;
        tbl_write_en = 1'b0;
        load_done    = 1'b0;
        load_err     = 1'b0;
        fin_code     = PAT_ERR_NONE;
        case (state_q)
            PAT_IDLE: begin
                ready_int = 1'b1;
                if (cfg_valid) state_d = PAT_PAYLOAD;
            end
            PAT_PAYLOAD: begin
                ready_int = 1'b1;
                if (cfg_valid && cnt_q == CNT_LAST) begin
                    if (class_q == PAT_ERR_NONE) begin
                        state_d = PAT_WRITE;
                    end else begin
                        load_err = 1'b1;
                        fin_code = class_q;
                        state_d  = PAT_IDLE;
                    end
                end
            end
            PAT_WRITE: begin
                tbl_write_en = 1'b1;
                state_d      = PAT_VERIFY;
            end
            PAT_VERIFY: begin
                if (tbl_entry == tbl_w_entry) begin
                    load_done = 1'b1;
                end else begin
                    load_err = 1'b1;
                    fin_code = PAT_ERR_VERIFY;
                end
                state_d = PAT_IDLE;
            end
            default: state_d = PAT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload shifts in from the top, so after NWORDS words the first one sits at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pid_q   <= '0;
            class_q <= PAT_ERR_NONE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else if (hs) begin
            if (state_q == PAT_IDLE) begin
                pid_q   <= cfg_data[3:0];
                class_q <= pat_pid_class(cfg_data[3:0], PAT_SIZE);
                cnt_q   <= '0;
            end else begin
                sr_q  <= (sr_q >> CFG_W) | (SR_W'(cfg_data) << (SR_W - CFG_W));
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= PAT_ERR_NONE;
        end else if (load_done || load_err) begin
            code_q <= fin_code;
        end
    end

endmodule

// File: tb/tb_pe_action_table_loader.sv
// Bench for pe_action_table_loader: table-driven packets, a table model with a corrupt pid,
// a scoreboard of expected completions, plus back-to-back and mid-packet reset sequences.
module tb_pe_action_table_loader;
    import pe_action_table_loader_pkg::*;

    localparam int TB_PAT_SIZE = 10;
    localparam int BAD_PID     = 9;

    typedef struct packed {
        logic        wr;
        logic [1:0]  code;
        logic [3:0]  pid;
        logic [47:0] entry;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    typedef struct {
        logic [15:0] hdr;
        logic [15:0] w0, w1, w2;
        int          max_gap;
        logic [1:0]  exp_code;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [15:0]     cfg_data;
    logic            tbl_write_en;
    logic [47:0]     tbl_w_entry;
    pid_t            tbl_pid;
    logic [47:0]     tbl_entry;
    logic            busy;
    logic            load_done;
    logic            load_err;
    logic [1:0]      err_code;
    pat_load_state_e dbg_state;

    logic [EXP_W-1:0] exp_q[$];
    logic [47:0]      table_mem[16];
    int               n_tests;
    int               n_fail;
    int               wr_cnt;
    int               wr_total;
    logic             prev_wr;
    logic [3:0]       wr_pid;
    logic [47:0]      wr_entry;

    pe_action_table_loader #(.PAT_SIZE(TB_PAT_SIZE)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_data     (cfg_data),
        .tbl_write_en (tbl_write_en),
        .tbl_w_entry  (tbl_w_entry),
        .tbl_pid      (tbl_pid),
        .tbl_entry    (tbl_entry),
        .busy         (busy),
        .load_done    (load_done),
        .load_err     (load_err),
        .err_code     (err_code),
        .dbg_state    (dbg_state)
    );

    // Clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Table model: registered write, combinational read; one pid reads back corrupted.
    always @(posedge clk) begin
        if (tbl_write_en) table_mem[tbl_pid] <= tbl_w_entry;
    end
    always_comb begin
        tbl_entry = table_mem[tbl_pid];
        if (int'({28'd0, tbl_pid}) == BAD_PID) tbl_entry = tbl_entry ^ 48'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_code(input logic [3:0] pid);
        int p;
        p = int'({28'd0, pid});
        if (p < 2) return 2'd1;
        if (p >= TB_PAT_SIZE) return 2'd2;
        if (p == BAD_PID) return 2'd3;
        return 2'd0;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            wr_cnt  = 0;
            prev_wr = 1'b0;
        end else begin
            exp_t e;
            if (prev_wr) begin
                check("done_or_err_after_write", 64'(load_done | load_err), 64'd1);
                check("ready_low_in_verify", 64'(cfg_ready), 64'd0);
            end
            check("done_err_exclusive", 64'(load_done & load_err), 64'd0);
            if (tbl_write_en) begin
                wr_cnt++;
                wr_total++;
                wr_pid   = tbl_pid;
                wr_entry = tbl_w_entry;
                check("ready_low_in_write", 64'(cfg_ready), 64'd0);
                check("state_write", 64'(dbg_state), 64'(PAT_WRITE));
                check("write_pid_legal", 64'(model_code(tbl_pid) == 2'd0 ||
                                             model_code(tbl_pid) == 2'd3), 64'd1);
            end
            if (load_done || load_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 64'(load_done | load_err), 64'd0);
                end else begin
                    e = exp_t'(exp_q.pop_front());
                    check("err_pulse", 64'(load_err), 64'(e.code != 2'd0));
                    check("err_code", 64'(err_code), 64'(e.code));
                    check("write_count", 64'(wr_cnt), e.wr ? 64'd1 : 64'd0);
                    if (e.wr) begin
                        check("write_pid", 64'(wr_pid), 64'(e.pid));
                        check("write_entry", 64'(wr_entry), 64'(e.entry));
                    end
                end
                wr_cnt = 0;
            end
            prev_wr = tbl_write_en;
        end
    end

    // Driver tasks: called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_word(input logic [15:0] d, input int max_gap);
        int   gap;
        logic hs;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            cfg_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b1;
        cfg_data  = d;
        hs = 1'b0;
        for (int t = 0; t < 64; t++) begin
            hs = cfg_ready;
            @(posedge clk);
            #1;
            if (hs) break;
        end
        if (!hs) check("handshake_timeout", 64'd1, 64'd0);
    endtask

    task automatic send_packet(input logic [15:0] hdr, input logic [15:0] w0,
                               input logic [15:0] w1, input logic [15:0] w2,
                               input int max_gap, input logic hold_valid);
        exp_t e;
        e.pid   = hdr[3:0];
        e.code  = model_code(hdr[3:0]);
        e.wr    = (e.code == 2'd0) || (e.code == 2'd3);
        e.entry = {w2, w1, w0};
        exp_q.push_back(EXP_W'(e));
        send_word(hdr, max_gap);
        send_word(w0, max_gap);
        send_word(w1, max_gap);
        send_word(w2, max_gap);
        if (!hold_valid) cfg_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            check("completion_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];

    initial begin
        int wr_before;
        n_tests   = 0;
        n_fail    = 0;
        wr_cnt    = 0;
        wr_total  = 0;
        prev_wr   = 1'b0;
        for (int i = 0; i < 16; i++) table_mem[i] = '0;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;

        vecs[0] = '{16'h0005, 16'h1111, 16'h2222, 16'h3333, 0, 2'd0};
        vecs[1] = '{16'h0001, 16'hAAAA, 16'hBBBB, 16'hCCCC, 0, 2'd1};
        vecs[2] = '{16'h0007, 16'h0F0F, 16'hF0F0, 16'h8001, 0, 2'd0};
        vecs[3] = '{16'h000F, 16'h1234, 16'h5678, 16'h9ABC, 2, 2'd2};
        vecs[4] = '{16'h000A, 16'hDEAD, 16'hBEEF, 16'hCAFE, 0, 2'd2};
        vecs[5] = '{16'h0005, 16'h1111, 16'h2222, 16'h3333, 5, 2'd0};
        vecs[6] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 3, 2'd1};
        vecs[7] = '{16'hFF02, 16'hFFFF, 16'h0000, 16'hFFFF, 1, 2'd0};
        vecs[8] = '{16'h0008, 16'h8000, 16'h7FFF, 16'h0001, 4, 2'd0};
        vecs[9] = '{16'h0009, 16'h5A5A, 16'hA5A5, 16'h3C3C, 2, 2'd3};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_write_en", 64'(tbl_write_en), 64'd0);
        check("rst_done_err", 64'({load_done, load_err}), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_pid", 64'(tbl_pid), 64'd0);
        check("rst_entry", 64'(tbl_w_entry), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ready", 64'(cfg_ready), 64'd1);

        // Table-driven packets
        for (int i = 0; i < 10; i++) begin
            check("vec_model_code", 64'(model_code(vecs[i].hdr[3:0])), 64'(vecs[i].exp_code));
            send_packet(vecs[i].hdr, vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].max_gap, 1'b0);
            wait_quiet();
            check("err_code_held", 64'(err_code), 64'(vecs[i].exp_code));
            check("idle_not_busy", 64'(busy), 64'd0);
        end

        // Reset after two payload words: no write, next packet loads normally
        wr_before = wr_total;
        send_word(16'h0004, 0);
        send_word(16'h4444, 0);
        send_word(16'h5555, 0);
        cfg_valid = 1'b0;
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(cfg_ready), 64'd0);
        check("mid_rst_err_code", 64'(err_code), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_no_write", 64'(wr_total - wr_before), 64'd0);
        send_packet(16'h0003, 16'h0123, 16'h4567, 16'h89AB, 0, 1'b0);
        wait_quiet();
        check("post_rst_err_code", 64'(err_code), 64'd0);

        // Back-to-back with cfg_valid held: headers wait through WRITE/VERIFY
        send_packet(16'h0006, 16'h6666, 16'h7777, 16'h8888, 0, 1'b1);
        send_packet(16'h0001, 16'h1010, 16'h2020, 16'h3030, 0, 1'b1);
        send_packet(16'h0002, 16'h0C0C, 16'hC0C0, 16'h0FF0, 0, 1'b1);
        send_packet(16'h000C, 16'h0001, 16'h0002, 16'h0004, 0, 1'b1);
        send_packet(16'h0004, 16'hFACE, 16'hB00C, 16'h0042, 0, 1'b0);
        wait_quiet();
        check("b2b_err_code", 64'(err_code), 64'd0);
        check("b2b_table_pid6", 64'(table_mem[6]), 64'h8888_7777_6666);
        check("b2b_table_pid2", 64'(table_mem[2]), 64'h0FF0_C0C0_0C0C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
